// File: rtl/dist_sq_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : dist_sq_gen_if
// Purpose : Request/result bundle between the focal-point source, the
//           squared-distance generator and the downstream square-root stage.
// Rev     : 1.0
// ============================================================================
interface dist_sq_gen_if;
  logic               start;
  logic signed [15:0] fp_x;
  logic        [15:0] fp_z;
  logic               ready;
  logic        [31:0] dout;
  logic               valid;
  logic        [7:0]  elem_idx;
  logic               busy;
  logic               done;
  logic        [3:0]  cstate;

  modport master (
    output start, fp_x, fp_z, ready,
    input  dout, valid, elem_idx, busy, done, cstate
  );

  modport slave (
    input  start, fp_x, fp_z, ready,
    output dout, valid, elem_idx, busy, done, cstate
  );
endinterface
`default_nettype wire

// File: rtl/dist_sq_gen.sv
`default_nettype none
// ============================================================================
// Module  : dist_sq_gen
// Purpose : Per-element squared distance (ex - fp_x)^2 + fp_z^2 for one focal
//           point. Define DIST_SQ_SATURATE_EN to clamp overflow to all-ones.
// Rev     : 1.0
// ============================================================================
module dist_sq_gen #(
  parameter int NUM_ELEM = 64,
  parameter int PITCH    = 64,
  parameter int ELEM_X0  = -2016
) (
  input logic          clk,
  input logic          reset,
  input logic          enable,
  dist_sq_gen_if.slave bus
);

`ifdef DIST_SQ_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [7:0] LAST_IDX = 8'(NUM_ELEM - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_DIFF = 4'd2,
    S_SQX  = 4'd3,
    S_SQZ  = 4'd4,
    S_SUM  = 4'd5,
    S_OUT  = 4'd6,
    S_NEXT = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t             r_state;
  logic signed [15:0] r_fp_x;
  logic        [15:0] r_fp_z;
  logic        [15:0] r_ex;
  logic        [16:0] r_dx;
  logic        [33:0] r_sqx;
  logic        [31:0] r_sqz;
  logic        [31:0] r_dout;
  logic               r_valid;
  logic               r_done;
  logic        [7:0]  r_idx;

  logic [15:0] w_ex;
  logic [16:0] w_dx;
  logic [33:0] w_dx_ext;
  logic [33:0] w_sqx;
  logic [31:0] w_sqz;
  logic [34:0] w_sum;
  logic [31:0] w_dout_next;

  assign w_ex     = 16'(ELEM_X0 + $signed({24'd0, r_idx}) * PITCH);
  // One extra bit on both operands keeps the difference exact for any inputs.
  assign w_dx     = {r_ex[15], r_ex} - {r_fp_x[15], r_fp_x};
  assign w_dx_ext = {{17{r_dx[16]}}, r_dx};
  // Low 34 bits of the two's-complement product equal the true square.
  assign w_sqx    = w_dx_ext * w_dx_ext;
  assign w_sqz    = {16'd0, r_fp_z} * {16'd0, r_fp_z};
  assign w_sum    = {1'b0, r_sqx} + {3'd0, r_sqz};

  assign w_dout_next = (SATURATE && (w_sum[34:32] != 3'd0)) ? 32'hFFFF_FFFF
                                                           : w_sum[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fp_x  <= '0;
      r_fp_z  <= '0;
      r_ex    <= '0;
      r_dx    <= '0;
      r_sqx   <= '0;
      r_sqz   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_fp_x  <= bus.fp_x;
            r_fp_z  <= bus.fp_z;
            r_idx   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_ex    <= w_ex;
          r_state <= S_DIFF;
        end
        S_DIFF: begin
          r_dx    <= w_dx;
          r_state <= S_SQX;
        end
        S_SQX: begin
          r_sqx   <= w_sqx;
          r_state <= S_SQZ;
        end
        S_SQZ: begin
          r_sqz   <= w_sqz;
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_dout  <= w_dout_next;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (bus.ready) begin
            r_valid <= 1'b0;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout     = r_dout;
  assign bus.valid    = r_valid;
  assign bus.elem_idx = r_idx;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.cstate   = r_state;

endmodule
`default_nettype wire
